// File: rtl/weight_bank_loader.sv
// weight_bank_loader
//   Double-buffered AXI-Stream kernel-weight loader. A new kernel streams into
//   the shadow bank while the active bank keeps driving weights_out. A swap
//   promotes the shadow bank without disturbing the datapath. TLAST framing is
//   checked against the expected beat count.
//
//   Optional build macro: WEIGHT_BANK_LOADER_AUTO_SWAP_EN
//     defined   - a correctly framed final beat swaps banks on the same edge
//                 (LOAD -> IDLE), so READY is never entered and swap_req is unused.
//     undefined - the full shadow bank waits in READY for swap_req.
module weight_bank_loader #(
    parameter int KERNEL_SIZE  = 16,
    parameter int WEIGHT_WIDTH = 8,
    parameter int BUS_WIDTH    = 32,
    localparam int REQ = KERNEL_SIZE * KERNEL_SIZE * WEIGHT_WIDTH,
    localparam int NT  = (REQ + BUS_WIDTH - 1) / BUS_WIDTH,
    localparam int PAD = NT * BUS_WIDTH
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [BUS_WIDTH-1:0] s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    input  logic                 load_start,
    input  logic                 swap_req,
    output logic [REQ-1:0]       weights_out,
    output logic                 weights_valid,
    output logic                 loading,
    output logic                 shadow_full,
    output logic                 active_bank,
    output logic                 load_err
);

    // Beat counter is one bit wider than strictly needed so NT==1 still has a
    // legal, non-zero-width counter.
    localparam int CW = $clog2(NT) + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_READY
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PAD-1:0]  bank0_q, bank1_q;
    logic            active_q;
    logic            valid_q;
    logic            err_q, err_d;
    logic            tready_q, loading_q, shadow_full_q;

    logic            beat;
    logic            shadow_we;
    logic            swap;
    logic [PAD-1:0]  shadow_cur;
    logic [PAD-1:0]  shadow_shifted;

    assign beat       = s_axis_tvalid && tready_q;
    assign shadow_cur = active_q ? bank0_q : bank1_q;

    // Shift the new beat into the LSBs so the first beat of a kernel ends up
    // in the MSBs once all NT beats have arrived.
    generate
        if (NT == 1) begin : g_single_beat
            assign shadow_shifted = s_axis_tdata;
        end else begin : g_multi_beat
            assign shadow_shifted = {shadow_cur[PAD-BUS_WIDTH-1:0], s_axis_tdata};
        end
    endgenerate

    // Next-state, counter and framing-error decisions.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        shadow_we = 1'b0;
        swap      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end

            S_LOAD: begin
                if (beat) begin
                    shadow_we = 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        if (s_axis_tlast) begin
`ifdef WEIGHT_BANK_LOADER_AUTO_SWAP_EN
                            swap    = 1'b1;
                            state_d = S_IDLE;
`else
                            state_d = S_READY;
`endif
                        end else begin
                            // Kernel longer than expected: swallow the rest of the frame.
                            err_d   = 1'b1;
                            state_d = S_DRAIN;
                        end
                    end else if (s_axis_tlast) begin
                        // Kernel shorter than expected: the partial shadow is abandoned.
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            S_DRAIN: begin
                if (beat && s_axis_tlast) begin
                    state_d = S_IDLE;
                end
            end

            S_READY: begin
                // load_start is deliberately not examined here: a swap wins.
                if (swap_req) begin
                    swap    = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // FSM state, bank storage and registered status outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            // NOTE: both weight banks are explicitly reset so weights_out is a known zero kernel out of reset.
            bank0_q       <= '0;
            bank1_q       <= '0;
            active_q      <= 1'b0;
            valid_q       <= 1'b0;
            err_q         <= 1'b0;
            tready_q      <= 1'b0;
            loading_q     <= 1'b0;
            shadow_full_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update in this block order-independent.
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            tready_q      <= (state_d == S_LOAD) || (state_d == S_DRAIN);
            loading_q     <= (state_d == S_LOAD);
            shadow_full_q <= (state_d == S_READY);

            if (shadow_we) begin
                if (active_q) begin
                    bank0_q <= shadow_shifted;
                end else begin
                    bank1_q <= shadow_shifted;
                end
            end

            if (swap) begin
                active_q <= ~active_q;
                valid_q  <= 1'b1;
            end
        end
    end

    assign weights_out   = active_q ? bank1_q[PAD-1 -: REQ] : bank0_q[PAD-1 -: REQ];
    assign weights_valid = valid_q;
    assign loading       = loading_q;
    assign shadow_full   = shadow_full_q;
    assign active_bank   = active_q;
    assign load_err      = err_q;
    assign s_axis_tready = tready_q;

endmodule

// File: tb/tb_weight_bank_loader.sv
// Directed bench for weight_bank_loader (KERNEL_SIZE=2, WEIGHT_WIDTH=8,
// BUS_WIDTH=24 -> 32-bit kernel, two 24-bit beats). Outputs are registered,
// so each expectation is checked one time unit after the clock edge.
module tb_weight_bank_loader;

  logic        clk;
  logic        rstn;
  logic [23:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic        load_start;
  logic        swap_req;
  logic [31:0] weights_out;
  logic        weights_valid;
  logic        loading;
  logic        shadow_full;
  logic        active_bank;
  logic        load_err;

  weight_bank_loader #(
    .KERNEL_SIZE (2),
    .WEIGHT_WIDTH(8),
    .BUS_WIDTH   (24)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .load_start   (load_start),
    .swap_req     (swap_req),
    .weights_out  (weights_out),
    .weights_valid(weights_valid),
    .loading      (loading),
    .shadow_full  (shadow_full),
    .active_bank  (active_bank),
    .load_err     (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic ok);
    compared++;
    if (ok !== 1'b1) begin
      mismatched++;
      $display("FAIL %s at %0t", name, $time);
    end
  endtask

  task automatic expect_out(input string name, input logic [31:0] w, input logic wv,
                            input logic ld, input logic sf, input logic ab,
                            input logic err, input logic rdy);
    check({name, ".weights_out"},   weights_out   === w);
    check({name, ".weights_valid"}, weights_valid === wv);
    check({name, ".loading"},       loading       === ld);
    check({name, ".shadow_full"},   shadow_full   === sf);
    check({name, ".active_bank"},   active_bank   === ab);
    check({name, ".load_err"},      load_err      === err);
    check({name, ".tready"},        s_axis_tready === rdy);
    if (weights_out !== w)
      $display("  %s: weights_out=%h want %h", name, weights_out, w);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
  endtask

  task automatic send_beat(input logic [23:0] data, input logic last);
    s_axis_tdata  = data;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    step();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  initial begin
    rstn          = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    load_start    = 1'b0;
    swap_req      = 1'b0;
    step();
    expect_out("reset", 32'h0, 0, 0, 0, 0, 0, 0);
    step();
    rstn = 1'b1;
    step();

`ifdef WEIGHT_BANK_LOADER_AUTO_SWAP_EN
    pulse_load();
    expect_out("t6_load", 32'h0, 0, 1, 0, 0, 0, 1);
    send_beat(24'h010203, 1'b0);
    expect_out("t6_beat0", 32'h0, 0, 1, 0, 0, 0, 1);
    send_beat(24'h040506, 1'b1);
    expect_out("t6_autoswap", 32'h01020304, 1, 0, 0, 1, 0, 0);
    pulse_swap();
    expect_out("t6_swap_ignored", 32'h01020304, 1, 0, 0, 1, 0, 0);
    step();
    expect_out("t6_idle", 32'h01020304, 1, 0, 0, 1, 0, 0);
`else
    pulse_load();
    expect_out("t1_load", 32'h0, 0, 1, 0, 0, 0, 1);
    send_beat(24'hAABBCC, 1'b0);
    expect_out("t1_beat0", 32'h0, 0, 1, 0, 0, 0, 1);
    send_beat(24'hDDEEFF, 1'b1);
    expect_out("t1_ready", 32'h0, 0, 0, 1, 0, 0, 0);
    pulse_swap();
    expect_out("t1_swap", 32'hAABBCCDD, 1, 0, 0, 1, 0, 0);

    pulse_load();
    send_beat(24'h112233, 1'b0);
    send_beat(24'h445566, 1'b1);
    expect_out("t2_ready", 32'hAABBCCDD, 1, 0, 1, 1, 0, 0);
    step();
    expect_out("t2_hold", 32'hAABBCCDD, 1, 0, 1, 1, 0, 0);
    load_start = 1'b1;
    pulse_swap();
    load_start = 1'b0;
    expect_out("t2_swap", 32'h11223344, 1, 0, 0, 0, 0, 0);
    step();
    expect_out("t2_no_launch", 32'h11223344, 1, 0, 0, 0, 0, 0);

    pulse_load();
    send_beat(24'h778899, 1'b1);
    expect_out("t3_err", 32'h11223344, 1, 0, 0, 0, 1, 0);
    step();
    expect_out("t3_err_clear", 32'h11223344, 1, 0, 0, 0, 0, 0);
    pulse_swap();
    expect_out("t3_swap_ignored", 32'h11223344, 1, 0, 0, 0, 0, 0);

    pulse_load();
    send_beat(24'h9A9A9A, 1'b0);
    send_beat(24'hBCBCBC, 1'b0);
    expect_out("t4_err", 32'h11223344, 1, 0, 0, 0, 1, 1);
    send_beat(24'h111111, 1'b0);
    expect_out("t4_drain", 32'h11223344, 1, 0, 0, 0, 0, 1);
    send_beat(24'h222222, 1'b0);
    send_beat(24'h333333, 1'b1);
    expect_out("t4_idle", 32'h11223344, 1, 0, 0, 0, 0, 0);
    pulse_load();
    send_beat(24'hCAFE01, 1'b0);
    send_beat(24'hBEEF02, 1'b1);
    pulse_swap();
    expect_out("t4_reload", 32'hCAFE01BE, 1, 0, 0, 1, 0, 0);
`endif

    pulse_load();
    send_beat(24'h123456, 1'b0);
`ifdef WEIGHT_BANK_LOADER_AUTO_SWAP_EN
    expect_out("t5_mid_load", 32'h01020304, 1, 1, 0, 1, 0, 1);
`else
    expect_out("t5_mid_load", 32'hCAFE01BE, 1, 1, 0, 1, 0, 1);
`endif
    step();
    rstn = 1'b0;
    #1;
    expect_out("t5_async_reset", 32'h0, 0, 0, 0, 0, 0, 0);
    step();
    rstn = 1'b1;
    step();
    expect_out("t5_after_reset", 32'h0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
